// File: rtl/vmicro16_apb_arbiter.sv
// Round-robin arbiter that funnels several APB masters onto one shared APB bus.
// Optional ACCESS-phase timeout is compiled in with the APB_ARB_TIMEOUT_EN macro.
module vmicro16_apb_arbiter #(
  parameter int MASTERS      = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int TIMEOUT_CLKS = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [MASTERS*ADDR_WIDTH-1:0]   S_PADDR,
  input  logic [MASTERS-1:0]              S_PWRITE,
  input  logic [MASTERS-1:0]              S_PSEL,
  input  logic [MASTERS-1:0]              S_PENABLE,
  input  logic [MASTERS*DATA_WIDTH-1:0]   S_PWDATA,
  output logic [DATA_WIDTH-1:0]           S_PRDATA,
  output logic [MASTERS-1:0]              S_PREADY,
  output logic [ADDR_WIDTH-1:0]           M_PADDR,
  output logic                            M_PWRITE,
  output logic                            M_PSEL,
  output logic                            M_PENABLE,
  output logic [DATA_WIDTH-1:0]           M_PWDATA,
  input  logic [DATA_WIDTH-1:0]           M_PRDATA,
  input  logic                            M_PREADY,
  output logic [$clog2(MASTERS)-1:0]      grant,
  output logic                            busy,
  output logic                            timeout
);

  localparam int GW = $clog2(MASTERS);

  // Handshake: a master holds S_PSEL high until it sees its S_PREADY bit
  // pulse for one cycle; the shared side completes when M_PREADY is sampled
  // high during ACCESS (M_PSEL && M_PENABLE).
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [GW-1:0]         r_grant;
  logic [GW-1:0]         r_last;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic                  r_pwrite;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic                  r_timeout;

  logic                  w_any;
  logic [GW-1:0]         w_pick;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic                  w_sel_write;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic [MASTERS-1:0]    w_pready;
  logic                  w_to_hit;
  logic                  w_unused;

  function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % MASTERS;
    return s[GW-1:0];
  endfunction

  // Scan from the farthest candidate to the nearest so the nearest requester
  // after the previous owner is the one left in w_pick.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_last;
    for (int k = MASTERS; k >= 1; k--) begin
      for (int i = 0; i < MASTERS; i++) begin
        if (S_PSEL[i] && (rr_idx(r_last, k) == i[GW-1:0])) begin
          w_any  = 1'b1;
          w_pick = i[GW-1:0];
        end
      end
    end
  end

  always_comb begin
    w_sel_addr  = '0;
    w_sel_write = 1'b0;
    w_sel_wdata = '0;
    for (int i = 0; i < MASTERS; i++) begin
      if (w_pick == i[GW-1:0]) begin
        w_sel_addr  = S_PADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_write = S_PWRITE[i];
        w_sel_wdata = S_PWDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW0 = $clog2(TIMEOUT_CLKS + 1);
  localparam int CW  = (CW0 > 8) ? CW0 : 8;

  logic [CW-1:0] r_cnt;

  // Cleared while in SETUP so it reads 0 in the first ACCESS cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == SETUP) begin
      r_cnt <= '0;
    end else if (r_state == ACCESS) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_to_hit = (r_cnt == CW'(TIMEOUT_CLKS - 1));
`else
  localparam int unused_timeout_clks = TIMEOUT_CLKS;
  assign w_to_hit = 1'b0;
`endif

  assign w_unused = ^S_PENABLE;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_next = SETUP;
      SETUP:   w_state_next = ACCESS;
      ACCESS:  if (M_PREADY || w_to_hit) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_last    <= GW'(MASTERS - 1);
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_prdata  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant  <= w_pick;
            r_last   <= w_pick;
            r_paddr  <= w_sel_addr;
            r_pwrite <= w_sel_write;
            r_pwdata <= w_sel_wdata;
          end
        end
        ACCESS: begin
          if (M_PREADY) begin
            r_prdata <= M_PRDATA;
          end else if (w_to_hit) begin
            r_prdata  <= '1;
            r_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_pready = '0;
    for (int i = 0; i < MASTERS; i++) begin
      w_pready[i] = (r_state == DONE) && (r_grant == i[GW-1:0]);
    end
  end

  // Outputs decode straight from the state register so an asynchronous reset
  // drops the shared bus without waiting for a clock edge.
  assign M_PSEL    = (r_state == SETUP) || (r_state == ACCESS);
  assign M_PENABLE = (r_state == ACCESS);
  assign M_PADDR   = M_PSEL ? r_paddr  : '0;
  assign M_PWRITE  = M_PSEL ? r_pwrite : 1'b0;
  assign M_PWDATA  = M_PSEL ? r_pwdata : '0;
  assign S_PREADY  = w_pready;
  assign S_PRDATA  = r_prdata;
  assign grant     = r_grant;
  assign busy      = (r_state != IDLE);
  assign timeout   = r_timeout;

endmodule

// File: doc/vmicro16_apb_arbiter.md
VMICRO16_APB_ARBITER -- requirements
Module: vmicro16_apb_arbiter

Interface
REQ-001 Parameter MASTERS, default 4: number of requesting APB masters; legal range 2..8.
REQ-002 Parameter DATA_WIDTH, default 16: width of the PWDATA and PRDATA buses.
REQ-003 Parameter ADDR_WIDTH, default 16: width of the PADDR bus.
REQ-004 Parameter TIMEOUT_CLKS, default 255: ACCESS-cycle limit, used only when APB_ARB_TIMEOUT_EN is defined.
REQ-005 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port S_PADDR, input, MASTERS*ADDR_WIDTH bits: per-master address, packed; master i occupies slice i.
REQ-008 Port S_PWRITE, input, MASTERS bits: per-master write flag.
REQ-009 Port S_PSEL, input, MASTERS bits: per-master request or select.
REQ-010 Port S_PENABLE, input, MASTERS bits: per-master enable; accepted but functionally ignored.
REQ-011 Port S_PWDATA, input, MASTERS*DATA_WIDTH bits: per-master write data, packed like S_PADDR.
REQ-012 Port S_PRDATA, output, DATA_WIDTH bits: read data, registered and broadcast to all masters.
REQ-013 Port S_PREADY, output, MASTERS bits: per-master completion pulse.
REQ-014 Port M_PADDR, output, ADDR_WIDTH bits: shared-bus address.
REQ-015 Port M_PWRITE, output, 1 bit: shared-bus write flag.
REQ-016 Port M_PSEL, output, 1 bit: shared-bus select; the downstream decoder produces PSELx from it.
REQ-017 Port M_PENABLE, output, 1 bit: shared-bus enable.
REQ-018 Port M_PWDATA, output, DATA_WIDTH bits: shared-bus write data.
REQ-019 Port M_PRDATA, input, DATA_WIDTH bits: shared-bus read data.
REQ-020 Port M_PREADY, input, 1 bit: shared-bus ready.
REQ-021 Port grant, output, $clog2(MASTERS) bits: index of the current or most recent owner.
REQ-022 Port busy, output, 1 bit: high in every state except IDLE.
REQ-023 Port timeout, output, 1 bit: one-cycle pulse when a transfer is aborted by timeout.

Function
REQ-024 State machine states SHALL be IDLE, SETUP, ACCESS and DONE, encoded in 2 bits.
REQ-025 In IDLE with any S_PSEL bit high, the arbiter SHALL pick the first requester at index (last+1), (last+2), ... modulo MASTERS, then latch it into grant, capture its PADDR/PWRITE/PWDATA and enter SETUP.
REQ-026 In IDLE with S_PSEL==0, the arbiter SHALL remain in IDLE with all M_* outputs idle.
REQ-027 SETUP SHALL last exactly one cycle: M_PSEL=1, M_PENABLE=0, M_* driven from the captured values; next state ACCESS.
REQ-028 ACCESS SHALL drive M_PSEL=1 and M_PENABLE=1 and hold until M_PREADY is sampled high.
REQ-029 On sampling M_PREADY high, the arbiter SHALL register M_PRDATA into S_PRDATA and enter DONE.
REQ-030 DONE SHALL last exactly one cycle: S_PREADY[grant]=1, all other S_PREADY bits 0, M_PSEL=0, M_PENABLE=0; next state IDLE.
REQ-031 Minimum transfer time SHALL be 4 cycles from the IDLE sample to the DONE cycle (IDLE, SETUP, ACCESS, DONE); a master never receives two grants back-to-back while others request.
REQ-032 Captured request values SHALL stay stable through SETUP and ACCESS even if the master changes or drops its inputs; the transfer completes regardless.
REQ-033 S_PRDATA SHALL hold its last value until the next completion; write transfers also update it with M_PRDATA.
REQ-034 The round-robin pointer SHALL update only on entry to SETUP; "last" after reset is MASTERS-1, so master 0 has first priority.
REQ-035 Requests arriving during SETUP, ACCESS or DONE SHALL wait; nothing is lost, because S_PSEL is level-held by the masters.

Reset
REQ-036 On reset assertion, immediately and independent of clk: state=IDLE, M_PSEL=0, M_PENABLE=0, M_PADDR=0, M_PWRITE=0, M_PWDATA=0, S_PREADY=0, S_PRDATA=0, grant=0, last=MASTERS-1, busy=0, timeout=0, timeout counter=0.
REQ-037 Reset asserted mid-transfer SHALL abandon the transfer without any S_PREADY pulse; the requester re-arbitrates after reset release.

Configuration
REQ-038 With macro APB_ARB_TIMEOUT_EN defined, an 8-bit-or-wider counter SHALL clear on entry to ACCESS and increment each ACCESS cycle.
REQ-039 With APB_ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CLKS without M_PREADY, the arbiter SHALL enter DONE with S_PRDATA all-ones and pulse timeout high for that DONE cycle.
REQ-040 Without APB_ARB_TIMEOUT_EN, ACCESS SHALL wait indefinitely, no counter SHALL exist, and timeout SHALL be tied 0 (port still present).

Verification
REQ-041 Single read: after reset, S_PSEL=4'b0001, addr 16'h0010, M_PREADY high in the first ACCESS cycle, M_PRDATA=16'hBEEF -> M_PSEL high 2 cycles, S_PREADY[0] pulse in the 4th cycle, S_PRDATA=16'hBEEF.
REQ-042 Round-robin: S_PSEL=4'b1111 held, zero-wait slave -> grant order 0,1,2,3,0 with one S_PREADY pulse per 4 cycles.
REQ-043 Wait states: master 2 write of 16'h1234, M_PREADY delayed 5 cycles -> M_PENABLE high 6 cycles, M_PWDATA stable at 16'h1234 throughout, S_PREADY[2] pulses once.
REQ-044 Mid-transfer reset: reset asserted during ACCESS -> M_PSEL and M_PENABLE drop to 0 without waiting for a clk edge, no S_PREADY pulse, grant=0.
REQ-045 Timeout (macro defined, TIMEOUT_CLKS=8): M_PREADY held low -> DONE after 8 ACCESS cycles, S_PRDATA=16'hFFFF, timeout pulse of 1 cycle; without the macro the arbiter stays in ACCESS for 100+ cycles.
